// File: rtl/dmem_pkg.sv
// Shared encodings for the synchronous data memory: access sizes, FSM states
// and the alignment rule used by the request error check.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offs);
        return ((size == SZ_HALF) && offs[0]) || ((size == SZ_WORD) && (offs != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_sync_if.sv
// Request/response channel between the MEM stage (master) and the data memory (slave).
interface dmem_sync_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_lane.sv
// Byte-lane steering: store byte enables / positioned write data, and load
// lane extraction with sign or zero extension, for either endianness.
module dmem_lane
    import dmem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [1:0]  size,
    input  logic [1:0]  offs,
    input  logic        sign_ext,
    input  logic [31:0] wdata_in,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    input  logic [31:0] rword,
    output logic [31:0] rdata_ext
);

    logic [1:0]  lane;
    logic [3:0]  mask;
    logic [4:0]  shamt;
    logic [31:0] rshift;

    always_comb begin
        mask = 4'b0000;
        lane = 2'd0;
        // lane is the lowest-numbered byte lane (bits [8*lane+7:8*lane]) touched
        case (size)
            SZ_BYTE: begin
                mask = 4'b0001;
                lane = BIG_ENDIAN ? (2'd3 - offs) : offs;
            end
            SZ_HALF: begin
                mask = 4'b0011;
                lane = BIG_ENDIAN ? (2'd2 - {offs[1], 1'b0}) : {offs[1], 1'b0};
            end
            SZ_WORD: mask = 4'b1111;
            default: ;
        endcase

        shamt      = {lane, 3'b000};
        byte_en    = mask << lane;
        wdata_lane = wdata_in << shamt;
        rshift     = rword >> shamt;

        rdata_ext = '0;
        case (size)
            SZ_BYTE: rdata_ext = {{24{sign_ext & rshift[7]}}, rshift[7:0]};
            SZ_HALF: rdata_ext = {{16{sign_ext & rshift[15]}}, rshift[15:0]};
            SZ_WORD: rdata_ext = rword;
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_sync.sv
// Clocked data memory: one outstanding load/store, commit/read at accept,
// single-cycle response LATENCY cycles later with misalign/range/size faults.
module dmem_sync
    import dmem_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = 32,
    parameter int LATENCY    = 1,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    dmem_sync_if.slave  bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              accept, enter_resp, live;
    logic              req_err;
    logic [IDX_W-1:0]  req_idx;

    logic              write_q, write_d;
    logic              signed_q, signed_d;
    logic              err_q, err_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        offs_q, offs_d;
    logic [31:0]       hold_q, hold_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic [1:0]        l_size, l_offs;
    logic              l_sign, cur_err, cur_write;
    logic [31:0]       l_rword;
    logic [3:0]        byte_en;
    logic [31:0]       wdata_lane, lane_rdata;

    logic [31:0]       mem_q [DEPTH] = '{default: '0};

    assign req_idx = bus.req_addr[IDX_W+1:2];
    assign req_err = (bus.req_size == SZ_ILL)
                   || misaligned(bus.req_size, bus.req_addr[1:0])
                   || ((bus.req_addr >> 2) >= ADDR_W'(DEPTH));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // In IDLE the lane logic sees the live request (store path and LATENCY==1
    // loads); afterwards it works from the captured request and held word.
    always_comb begin
        live       = (state_q == IDLE);
        enter_resp = (state_d == RESP);
        l_size     = live ? bus.req_size       : size_q;
        l_offs     = live ? bus.req_addr[1:0]  : offs_q;
        l_sign     = live ? bus.req_signed     : signed_q;
        l_rword    = live ? mem_q[req_idx]     : hold_q;
        cur_err    = live ? req_err            : err_q;
        cur_write  = live ? bus.req_write      : write_q;

        write_d  = accept ? bus.req_write      : write_q;
        signed_d = accept ? bus.req_signed     : signed_q;
        err_d    = accept ? req_err            : err_q;
        size_d   = accept ? bus.req_size       : size_q;
        offs_d   = accept ? bus.req_addr[1:0]  : offs_q;
        hold_d   = accept ? mem_q[req_idx]     : hold_q;

        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        if (enter_resp) begin
            resp_rdata_d = (cur_err || cur_write) ? 32'd0 : lane_rdata;
            resp_err_d   = cur_err;
        end
    end

    dmem_lane #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
        .size       (l_size),
        .offs       (l_offs),
        .sign_ext   (l_sign),
        .wdata_in   (bus.req_wdata),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .rword      (l_rword),
        .rdata_ext  (lane_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        write_q  <= write_d;
        signed_q <= signed_d;
        err_q    <= err_d;
        size_q   <= size_d;
        offs_q   <= offs_d;
        hold_q   <= hold_d;
    end

    // Array is never reset; faulting stores never touch it.
    always_ff @(posedge clk) begin
        if (accept && !reset && bus.req_write && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem_q[req_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
            end
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_sync.sv
// Directed bench for dmem_sync: four instances cover LATENCY 1/3/4 and both
// endiannesses; each scenario task carries its own hand-computed expectations.
`timescale 1ns/1ps
module tb_dmem_sync;
    import dmem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst2;
    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        vld [4];
    logic        wr, sg;
    logic [1:0]  sz;
    logic [31:0] addr, wdata;
    logic        rdy [4];
    logic        rv  [4];
    logic        er  [4];
    logic [31:0] rd  [4];

    int total  = 0;
    int passed = 0;

    // 0: LAT1 big-endian, 1: LAT1 little-endian, 2: LAT3 big-endian, 3: LAT4 big-endian
    dmem_sync_if #(.ADDR_W(32)) ifs [4] ();

    for (genvar g = 0; g < 4; g++) begin : g_dut
        assign ifs[g].req_valid  = vld[g];
        assign ifs[g].req_write  = wr;
        assign ifs[g].req_size   = sz;
        assign ifs[g].req_signed = sg;
        assign ifs[g].req_addr   = addr;
        assign ifs[g].req_wdata  = wdata;
        assign rdy[g] = ifs[g].req_ready;
        assign rv[g]  = ifs[g].resp_valid;
        assign er[g]  = ifs[g].resp_err;
        assign rd[g]  = ifs[g].resp_rdata;

        dmem_sync #(
            .DEPTH      (1024),
            .ADDR_W     (32),
            .LATENCY    ((g == 2) ? 3 : (g == 3) ? 4 : 1),
            .BIG_ENDIAN (g != 1)
        ) dut (
            .clk   (clk),
            .reset ((g == 2) ? (rst | rst2) : rst),
            .bus   (ifs[g])
        );
    end

    task automatic do_access(input int d, input logic w, input logic [1:0] s, input logic sgn,
                             input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] rdata, output logic err,
                             output int lat, output logic rv_after);
        int n;
        wr = w; sz = s; sg = sgn; addr = a; wdata = wd;
        vld[d] = 1'b1;
        n = 0;
        while (!rdy[d] && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        vld[d] = 1'b0;
        lat = 1;
        while (!rv[d] && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        total++;
        if (!rv[d]) $display("FAIL resp_timeout dut%0d addr=%h: resp_valid=0 want 1", d, a);
        else passed++;
        rdata = rd[d];
        err   = er[d];
        @(posedge clk); #1;
        rv_after = rv[d];
    endtask

    task automatic test_reset();
        total++; if (rdy[0] !== 1'b1) $display("FAIL rst_ready got %b want 1", rdy[0]); else passed++;
        total++; if (rv[0] !== 1'b0) $display("FAIL rst_resp_valid got %b want 0", rv[0]); else passed++;
        total++; if (rd[0] !== 32'd0) $display("FAIL rst_rdata got %h want 0", rd[0]); else passed++;
        total++; if (er[0] !== 1'b0) $display("FAIL rst_err got %b want 0", er[0]); else passed++;
        total++; if (rdy[3] !== 1'b1) $display("FAIL rst_ready_lat4 got %b want 1", rdy[3]); else passed++;
    endtask

    task automatic test_reset_mid_op();
        int seen;
        wr = 1'b0; sz = SZ_WORD; sg = 1'b0; addr = 32'h20; wdata = '0;
        vld[2] = 1'b1;
        @(posedge clk); #1;
        vld[2] = 1'b0;
        total++; if (rdy[2] !== 1'b0) $display("FAIL midrst_accept ready got %b want 0", rdy[2]); else passed++;
        rst2 = 1'b1;
        @(posedge clk); #1;
        rst2 = 1'b0;
        total++; if (rdy[2] !== 1'b1) $display("FAIL midrst_ready got %b want 1", rdy[2]); else passed++;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (rv[2]) seen++;
            @(posedge clk); #1;
        end
        total++; if (seen !== 0) $display("FAIL midrst_no_resp got %0d pulses want 0", seen); else passed++;
    endtask

    task automatic test_store_load();
        logic [31:0] r; logic e, ra; int lat;
        do_access(0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, r, e, lat, ra);
        total++; if (e !== 1'b0) $display("FAIL sw_err got %b want 0", e); else passed++;
        total++; if (r !== 32'd0) $display("FAIL sw_rdata got %h want 0", r); else passed++;
        do_access(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, r, e, lat, ra);
        total++; if (r !== 32'hDEADBEEF) $display("FAIL lw_data got %h want deadbeef", r); else passed++;
        total++; if (e !== 1'b0) $display("FAIL lw_err got %b want 0", e); else passed++;
        total++; if (lat !== 1) $display("FAIL lw_latency got %0d want 1", lat); else passed++;
        total++; if (ra !== 1'b0) $display("FAIL lw_pulse resp_valid next cycle got %b want 0", ra); else passed++;
        total++; if (rd[0] !== 32'hDEADBEEF) $display("FAIL lw_hold got %h want deadbeef", rd[0]); else passed++;
    endtask

    task automatic test_be_subword();
        logic [31:0] r; logic e, ra; int lat;
        do_access(0, 1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, r, e, lat, ra);
        total++; if (r !== 32'hFFFFFFAD) $display("FAIL lb_11 got %h want ffffffad", r); else passed++;
        do_access(0, 1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, r, e, lat, ra);
        total++; if (r !== 32'h000000AD) $display("FAIL lbu_11 got %h want 000000ad", r); else passed++;
        do_access(0, 1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, r, e, lat, ra);
        total++; if (r !== 32'hFFFFBEEF) $display("FAIL lh_12 got %h want ffffbeef", r); else passed++;
        do_access(0, 1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0, r, e, lat, ra);
        total++; if (r !== 32'h0000DEAD) $display("FAIL lhu_10 got %h want 0000dead", r); else passed++;
    endtask

    task automatic test_partial_store();
        logic [31:0] r; logic e, ra; int lat;
        do_access(0, 1'b1, SZ_BYTE, 1'b0, 32'h13, 32'hAAAAAA12, r, e, lat, ra);
        do_access(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, r, e, lat, ra);
        total++; if (r !== 32'hDEADBE12) $display("FAIL sb_be got %h want deadbe12", r); else passed++;
        do_access(1, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, r, e, lat, ra);
        do_access(1, 1'b1, SZ_BYTE, 1'b0, 32'h10, 32'h00000012, r, e, lat, ra);
        do_access(1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, r, e, lat, ra);
        total++; if (r !== 32'hDEADBE12) $display("FAIL sb_le got %h want deadbe12", r); else passed++;
        do_access(1, 1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, r, e, lat, ra);
        total++; if (r !== 32'hFFFFDEAD) $display("FAIL lh_le got %h want ffffdead", r); else passed++;
    endtask

    task automatic test_faults();
        logic [31:0] r; logic e, ra; int lat;
        do_access(0, 1'b0, SZ_WORD, 1'b0, 32'h2, 32'h0, r, e, lat, ra);
        total++; if (e !== 1'b1) $display("FAIL lw_misalign err got %b want 1", e); else passed++;
        total++; if (r !== 32'd0) $display("FAIL lw_misalign rdata got %h want 0", r); else passed++;
        total++; if (er[0] !== 1'b1) $display("FAIL err_hold got %b want 1", er[0]); else passed++;
        do_access(0, 1'b1, SZ_HALF, 1'b0, 32'h11, 32'h00001234, r, e, lat, ra);
        total++; if (e !== 1'b1) $display("FAIL sh_misalign err got %b want 1", e); else passed++;
        do_access(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, r, e, lat, ra);
        total++; if (r !== 32'hDEADBE12) $display("FAIL sh_no_write got %h want deadbe12", r); else passed++;
        do_access(0, 1'b0, SZ_WORD, 1'b0, 32'h1000, 32'h0, r, e, lat, ra);
        total++; if (e !== 1'b1) $display("FAIL lw_range err got %b want 1", e); else passed++;
        do_access(0, 1'b0, SZ_WORD, 1'b0, 32'hFFC, 32'h0, r, e, lat, ra);
        total++; if (e !== 1'b0) $display("FAIL lw_last_word err got %b want 0", e); else passed++;
        do_access(0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, r, e, lat, ra);
        total++; if (e !== 1'b1) $display("FAIL size11 err got %b want 1", e); else passed++;
        total++; if (r !== 32'd0) $display("FAIL size11 rdata got %h want 0", r); else passed++;
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int rsp[$];
        int low;
        logic [31:0] first_rd;
        low = 0;
        first_rd = 32'hFFFFFFFF;
        wr = 1'b0; sz = SZ_WORD; sg = 1'b0; addr = 32'h100; wdata = '0;
        vld[3] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (rdy[3]) acc.push_back(cyc + 1);
            else low++;
            if (rv[3]) begin
                if (rsp.size() == 0) first_rd = rd[3];
                rsp.push_back(cyc);
            end
            @(posedge clk); #1;
            addr = addr + 32'd4;
        end
        vld[3] = 1'b0;
        total++;
        if (acc.size() < 3 || rsp.size() < 3) begin
            $display("FAIL b2b_counts accepts=%0d resps=%0d want >=3 each", acc.size(), rsp.size());
        end else begin
            passed++;
            total++; if (acc[1] - acc[0] !== 5) $display("FAIL b2b_spacing0 got %0d want 5", acc[1] - acc[0]); else passed++;
            total++; if (acc[2] - acc[1] !== 5) $display("FAIL b2b_spacing1 got %0d want 5", acc[2] - acc[1]); else passed++;
            total++; if (rsp[0] - acc[0] + 1 !== 4) $display("FAIL b2b_latency0 got %0d want 4", rsp[0] - acc[0] + 1); else passed++;
            total++; if (rsp[2] - acc[2] + 1 !== 4) $display("FAIL b2b_latency2 got %0d want 4", rsp[2] - acc[2] + 1); else passed++;
        end
        total++; if (low !== 12) $display("FAIL b2b_ready_low got %0d want 12", low); else passed++;
        total++; if (first_rd !== 32'd0) $display("FAIL b2b_zero_init got %h want 0", first_rd); else passed++;
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b0;
        for (int i = 0; i < 4; i++) vld[i] = 1'b0;
        wr = 1'b0; sz = SZ_WORD; sg = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        test_reset();
        test_reset_mid_op();
        test_store_load();
        test_be_subword();
        test_partial_store();
        test_faults();
        test_back_to_back();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
